// File: rtl/fp7_alu_pkg.sv
// fp7_alu_pkg: shared widths, saturation constants and helpers for the fp7 ALU datapath
package fp7_alu_pkg;
  localparam int EXP_WIDTH_DEFAULT = 8;
  localparam int MANT_WIDTH_DEFAULT = 24;
  localparam logic [MANT_WIDTH_DEFAULT-1:0] MANT_MAX = {1'b0, {(MANT_WIDTH_DEFAULT-1){1'b1}}};
  localparam logic [MANT_WIDTH_DEFAULT-1:0] MANT_MIN = {1'b1, {(MANT_WIDTH_DEFAULT-1){1'b0}}};
  localparam logic [EXP_WIDTH_DEFAULT-1:0] EXP_ONES = '1;
  function automatic int shift_width(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/fp7_alu_leading_sign_counter.sv
// fp7_alu_leading_sign_counter: redundant sign-bit count (normalizing left shift) and zero detect
module fp7_alu_leading_sign_counter
  import fp7_alu_pkg::*;
#(
  parameter int WIDTH = MANT_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0]                    value,
  output logic [shift_width(WIDTH)-1:0]       count,
  output logic                                zero
);
  logic run;
  always_comb begin
    count = '0;
    run = 1'b1;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (run && value[i] == value[WIDTH-1]) count = count + 1'b1;
      else run = 1'b0;
    end
  end
  assign zero = ~|value;
endmodule

// File: rtl/fp7_alu_add_normalize_stage.sv
// fp7_alu_add_normalize_stage: two-stage add + renormalize pipeline with valid/ready backpressure
module fp7_alu_add_normalize_stage
  import fp7_alu_pkg::*;
#(
  parameter int EXPONENT_WIDTH = EXP_WIDTH_DEFAULT,
  parameter int MANTISSA_WIDTH = MANT_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [EXPONENT_WIDTH-1:0] i_exponent_big,
  input  logic [MANTISSA_WIDTH-1:0] i_mantissa_big,
  input  logic [MANTISSA_WIDTH-1:0] i_mantissa_aligned,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [EXPONENT_WIDTH-1:0] o_exponent,
  output logic [MANTISSA_WIDTH-1:0] o_mantissa,
  output logic                      o_zero,
  output logic                      o_overflow,
  output logic                      o_underflow
);
  localparam int EW = EXPONENT_WIDTH;
  localparam int MW = MANTISSA_WIDTH;
  localparam int SW = shift_width(MW);
  localparam logic [MW-1:0] m_max = {1'b0, {(MW-1){1'b1}}};
  localparam logic [MW-1:0] m_min = {1'b1, {(MW-1){1'b0}}};
  localparam logic [EW-1:0] exp_ones = '1;
  logic s1_valid, s2_valid, adv1, adv2;
  logic [MW:0] sum, s1_sum;
  logic [EW-1:0] s1_exp, n_exp;
  logic [MW-1:0] n_mant;
  logic [SW-1:0] lsc;
  logic lsc_zero, carry, is_zero, ovf, unf;
  assign adv2 = ~s2_valid | i_ready;
  assign adv1 = ~s1_valid | adv2;
  assign o_ready = adv1;
  assign o_valid = s2_valid;
  assign sum = {i_mantissa_big[MW-1], i_mantissa_big} + {i_mantissa_aligned[MW-1], i_mantissa_aligned};
  fp7_alu_leading_sign_counter #(.WIDTH(MW)) u_lsc (
    .value(s1_sum[MW-1:0]),
    .count(lsc),
    .zero (lsc_zero)
  );
  // A carry out of the low MW bits means the true sign lives in s1_sum[MW]
  always_comb begin
    carry = s1_sum[MW] ^ s1_sum[MW-1];
    is_zero = lsc_zero & ~carry;
    ovf = carry & (s1_exp == exp_ones);
    unf = ~carry & ~lsc_zero & (EW'(lsc) > s1_exp);
    n_mant = (is_zero | unf) ? '0 :
             ovf ? (s1_sum[MW] ? m_min : m_max) :
             carry ? s1_sum[MW:1] : s1_sum[MW-1:0] << lsc;
    n_exp = (is_zero | unf) ? '0 :
            ovf ? exp_ones :
            carry ? s1_exp + 1'b1 : s1_exp - EW'(lsc);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum <= '0;
      s1_exp <= '0;
      s2_valid <= 1'b0;
      o_mantissa <= '0;
      o_exponent <= '0;
      o_zero <= 1'b0;
      o_overflow <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= i_valid;
        s1_sum <= sum;
        s1_exp <= i_exponent_big;
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        o_mantissa <= s1_valid ? n_mant : '0;
        o_exponent <= s1_valid ? n_exp : '0;
        o_zero <= s1_valid & (is_zero | unf);
        o_overflow <= s1_valid & ovf;
        o_underflow <= s1_valid & unf;
      end
    end
  end
endmodule

// File: tb/tb_fp7_alu_add_normalize_stage.sv
// tb_fp7_alu_add_normalize_stage: directed vector table plus backpressure and mid-flight reset sequences
module tb_fp7_alu_add_normalize_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_valid = 1'b0;
  logic i_ready = 1'b1;
  logic [7:0] i_exponent_big = '0;
  logic [23:0] i_mantissa_big = '0;
  logic [23:0] i_mantissa_aligned = '0;
  logic o_ready, o_valid, o_zero, o_overflow, o_underflow;
  logic [7:0] o_exponent;
  logic [23:0] o_mantissa;
  int total = 0;
  int passed = 0;
  typedef struct {
    logic [23:0] big;
    logic [23:0] al;
    logic [7:0]  e;
    logic [23:0] m;
    logic [7:0]  eo;
    logic [2:0]  fl;
  } vec_t;
  vec_t tv[13];
  fp7_alu_add_normalize_stage dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_exponent_big(i_exponent_big), .i_mantissa_big(i_mantissa_big),
    .i_mantissa_aligned(i_mantissa_aligned), .o_valid(o_valid), .i_ready(i_ready),
    .o_exponent(o_exponent), .o_mantissa(o_mantissa), .o_zero(o_zero),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] r);
    total++;
    if (a === r) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, r);
  endtask
  task automatic drive(input int k);
    i_mantissa_big = tv[k].big;
    i_mantissa_aligned = tv[k].al;
    i_exponent_big = tv[k].e;
  endtask
  task automatic chk_out(input string n, input int k);
    chk({n, "_m"}, 32'(o_mantissa), 32'(tv[k].m));
    chk({n, "_e"}, 32'(o_exponent), 32'(tv[k].eo));
    chk({n, "_fl"}, 32'({o_zero, o_overflow, o_underflow}), 32'(tv[k].fl));
  endtask
  task automatic run_vec(input int k);
    @(negedge clk);
    i_valid = 1'b1;
    drive(k);
    #1 chk($sformatf("v%0d_rdy", k), 32'(o_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    #1 chk($sformatf("v%0d_lat1", k), 32'(o_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d_lat2", k), 32'(o_valid), 32'd1);
    chk_out($sformatf("v%0d", k), k);
  endtask
  initial begin
    int bp[4] = '{0, 2, 8, 11};
    int sent = 0;
    int got = 0;
    bit hold = 1'b0;
    bit saw_stall = 1'b0;
    logic [23:0] hm;
    logic [7:0] he;
    tv[0]  = '{24'h400000, 24'h400000, 8'd10,  24'h400000, 8'd11,  3'b000};
    tv[1]  = '{24'h400000, 24'hC00000, 8'd20,  24'h000000, 8'd0,   3'b100};
    tv[2]  = '{24'h400000, 24'hE00000, 8'd9,   24'h400000, 8'd8,   3'b000};
    tv[3]  = '{24'h400000, 24'hBFFFFF, 8'd3,   24'h000000, 8'd0,   3'b101};
    tv[4]  = '{24'h600000, 24'h600000, 8'd255, 24'h7FFFFF, 8'd255, 3'b010};
    tv[5]  = '{24'hA00000, 24'hA00000, 8'd255, 24'h800000, 8'd255, 3'b010};
    tv[6]  = '{24'hFFFFFF, 24'h000000, 8'd30,  24'h800000, 8'd7,   3'b000};
    tv[7]  = '{24'h000001, 24'h000000, 8'd22,  24'h400000, 8'd0,   3'b000};
    tv[8]  = '{24'h500000, 24'h100000, 8'd5,   24'h600000, 8'd5,   3'b000};
    tv[9]  = '{24'h600000, 24'h600000, 8'd254, 24'h600000, 8'd255, 3'b000};
    tv[10] = '{24'hC00000, 24'h000000, 8'd5,   24'h800000, 8'd4,   3'b000};
    tv[11] = '{24'h800000, 24'h800000, 8'd100, 24'h800000, 8'd101, 3'b000};
    tv[12] = '{24'h000001, 24'h000000, 8'd21,  24'h000000, 8'd0,   3'b101};
    #3;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_m", 32'(o_mantissa), 32'd0);
    chk("rst_flags", 32'({o_zero, o_overflow, o_underflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_ready", 32'(o_ready), 32'd1);
    for (int k = 0; k < 13; k++) run_vec(k);
    // Backpressure: i_ready low for cycles 2..6 while four operands stream in
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      i_ready = !(c >= 2 && c <= 6);
      i_valid = (sent < 4);
      if (sent < 4) drive(bp[sent]);
      #1;
      if (!o_ready) saw_stall = 1'b1;
      if (hold) begin
        chk($sformatf("bp_hold_m_c%0d", c), 32'(o_mantissa), 32'(hm));
        chk($sformatf("bp_hold_e_c%0d", c), 32'(o_exponent), 32'(he));
      end
      hold = o_valid && !i_ready;
      hm = o_mantissa;
      he = o_exponent;
      if (o_valid && i_ready) begin
        chk_out($sformatf("bp%0d", got), bp[got]);
        got++;
      end
      if (i_valid && o_ready) sent++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk("bp_count", 32'(got), 32'd4);
    chk("bp_stall", 32'(saw_stall), 32'd1);
    // Mid-flight reset with two entries held in the pipe
    @(negedge clk);
    @(negedge clk);
    i_ready = 1'b0;
    i_valid = 1'b1;
    drive(0);
    @(posedge clk);
    @(negedge clk);
    drive(2);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    chk("mr_pre_valid", 32'(o_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(o_valid), 32'd0);
    chk("mr_m", 32'(o_mantissa), 32'd0);
    chk("mr_e", 32'(o_exponent), 32'd0);
    chk("mr_flags", 32'({o_zero, o_overflow, o_underflow}), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    i_ready = 1'b1;
    #1 chk("mr_ready", 32'(o_ready), 32'd1);
    run_vec(5);
    @(negedge clk);
    chk("mr_drain", 32'(o_valid), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fp7_alu_add_normalize_stage.md
Name: fp7_alu_add_normalize_stage

Overview:
Pipeline stage directly downstream of the fp7 ALU alignment stage. It consumes the big-operand mantissa, the aligned (right-shifted) small mantissa and the big exponent, then adds the two signed mantissas. It renormalizes the sum and produces the final exponent and mantissa with status flags. It is a 2-deep registered pipeline with valid/ready flow control so the ALU back end can stall.

Parameters:
EXPONENT_WIDTH, 8, unsigned biased exponent width
MANTISSA_WIDTH, 24, signed two's-complement mantissa width; normalized form has bit[MW-1] != bit[MW-2]

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_valid  in  1  upstream operands valid
o_ready  out  1  stage can accept operands this cycle
i_exponent_big  in  EXPONENT_WIDTH  exponent of larger operand
i_mantissa_big  in  MANTISSA_WIDTH  signed mantissa of larger operand
i_mantissa_aligned  in  MANTISSA_WIDTH  signed aligned mantissa of smaller operand
o_valid  out  1  result valid
i_ready  in  1  downstream accepts result
o_exponent  out  EXPONENT_WIDTH  result exponent
o_mantissa  out  MANTISSA_WIDTH  normalized signed result mantissa
o_zero  out  1  result is exact zero
o_overflow  out  1  exponent saturated high
o_underflow  out  1  result flushed to zero on exponent underflow

Behaviour:
- Reset is one clock, asynchronous and active-low: clk, rst_n. While rst_n=0 all valids and all outputs are 0. o_ready is combinational and equals 1 after reset.
- Handshake:
  - A transfer occurs when valid and ready are both 1.
  - adv2 = ~s2_valid | i_ready. adv1 = ~s1_valid | adv2. o_ready = adv1.
  - o_ready never depends on i_valid.
- S1 (add), loaded on adv1:
  - sum = sext(i_mantissa_big) + sext(i_mantissa_aligned), MW+1 bits.
  - Register sum and exponent; s1_valid <= i_valid.
- S2 (normalize), loaded on adv2; s2_valid <= s1_valid.
  - Zero: sum==0 -> mantissa 0, exponent 0, o_zero=1.
  - Carry-out: sum[MW] != sum[MW-1] -> mantissa = sum[MW:1] (truncate, no rounding), exponent+1.
    - If exponent was all-ones: exponent stays all-ones, mantissa saturates to 0x7F..F (positive) or 0x80..0 (negative), o_overflow=1.
  - Otherwise: L = leading-sign count of sum[MW-1:0] minus 1, range 0..MW-1. Example: all-ones gives L=MW-1 and result 0x80..0.
    - If L <= exponent: mantissa = sum << L, exponent - L.
    - If L > exponent: flush to mantissa 0 and exponent 0, o_underflow=1, o_zero=1.
- Flags are mutually exclusive except underflow, which also sets zero. Flags are registered with the data.
- Latency: 2 cycles from input transfer to o_valid with no stall. Throughput is 1 per cycle.
- Stall: while o_valid & ~i_ready, o_* are held stable. S1 accepts one more entry, then o_ready=0. No data is lost or reordered.
- If a valid sits in S1 and adv2=1 on the same cycle as an input transfer, S2 takes the S1 entry and S1 takes the new input.
- Reset asserted mid-stream discards both entries immediately. No output is produced for them.

Decomposition:
- Package fp7_alu_pkg:
  - EXPONENT_WIDTH and MANTISSA_WIDTH defaults.
  - Log2-based width for the shift count.
  - Max/min mantissa saturation constants.
  - Exponent all-ones constant.
- One combinational sub-module fp7_alu_leading_sign_counter: sum in, L and zero flag out. It is reused by the multiply path.

Test Plan:
All cases use EW=8, MW=24.
- Basic carry: big=0x400000, aligned=0x400000, exp=10, i_ready=1 -> 2 cycles later o_mantissa=0x400000, o_exponent=11, no flags.
- Cancellation: big=0x400000, aligned=0xC00000, exp=20 -> o_mantissa=0, o_exponent=0, o_zero=1.
- Left normalize: big=0x400000, aligned=0xE00000, exp=9 -> o_mantissa=0x400000, o_exponent=8. Separately, big=0x400000, aligned=0xBFFFFF, exp=3 -> sum=-1, L=23>3, o_underflow=1, o_zero=1.
- Overflow: big=0x600000, aligned=0x600000, exp=255 -> o_exponent=255, o_mantissa=0x7FFFFF, o_overflow=1. Negative case: big=0xA00000, aligned=0xA00000, exp=255 -> o_mantissa=0x800000.
- Backpressure: stream 4 operand sets, i_ready=0 for cycles 2-6 -> o_ready falls after 2 held entries, o_* stable while stalled, all 4 results emerge in order once i_ready=1.
- Reset mid-flight: 2 entries in pipe, pulse rst_n low 1 cycle asynchronously -> o_valid=0 and outputs 0 immediately, o_ready=1 after release, next input appears 2 cycles after acceptance.
